// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller between the
// datapath MEM port and backing memory; one cache_line instance per index.

module cache_line #(
  parameter int WORD_SIZE   = 16,
  parameter int OFFSET_BITS = 2,
  parameter int TAG_BITS    = 12
) (
  input  logic                                           clk,
  input  logic                                           reset_n,
  input  logic                                           fill_en,
  input  logic [TAG_BITS-1:0]                            fill_tag,
  input  logic [(1<<OFFSET_BITS)-1:0][WORD_SIZE-1:0]     fill_data,
  input  logic                                           wr_en,
  input  logic [OFFSET_BITS-1:0]                         wr_off,
  input  logic [WORD_SIZE-1:0]                           wr_data,
  output logic                                           valid,
  output logic [TAG_BITS-1:0]                            tag,
  output logic [(1<<OFFSET_BITS)-1:0][WORD_SIZE-1:0]     data
);

  always_ff @(posedge clk) begin
    if (!reset_n)     valid <= 1'b0;
    else if (fill_en) valid <= 1'b1;
  end

  // Tag/data need no reset: they are only observed through valid.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag  <= fill_tag;
      data <= fill_data;
    end else if (wr_en) begin
      data[wr_off] <= wr_data;
    end
  end

endmodule

module cache_ctrl #(
  parameter int WORD_SIZE   = 16,
  parameter int INDEX_BITS  = 2,
  parameter int OFFSET_BITS = 2,
  parameter int TAG_BITS    = WORD_SIZE - INDEX_BITS - OFFSET_BITS
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  cpu_read,
  input  logic                                  cpu_write,
  input  logic [WORD_SIZE-1:0]                  cpu_addr,
  input  logic [WORD_SIZE-1:0]                  cpu_wdata,
  output logic [WORD_SIZE-1:0]                  cpu_rdata,
  output logic                                  cpu_ready,
  output logic                                  mem_req,
  output logic                                  mem_we,
  output logic [WORD_SIZE-1:0]                  mem_addr,
  output logic [WORD_SIZE-1:0]                  mem_wdata,
  input  logic [(WORD_SIZE<<OFFSET_BITS)-1:0]   mem_rdata,
  input  logic                                  mem_ready,
  output logic [WORD_SIZE-1:0]                  access_count,
  output logic [WORD_SIZE-1:0]                  hit_count
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << OFFSET_BITS;

  typedef struct packed {
    logic [TAG_BITS-1:0]    tag;
    logic [INDEX_BITS-1:0]  idx;
    logic [OFFSET_BITS-1:0] off;
  } addr_t;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t state, state_d;
  addr_t  cpu_a;
  logic   hit, fill_en, wr_en, miss_set, rd_done, miss_flag;
  logic   mem_req_d, mem_we_d;
  logic [WORD_SIZE-1:0] mem_addr_d, mem_wdata_d;

  logic [LINES-1:0]                            line_valid;
  logic [LINES-1:0][TAG_BITS-1:0]              line_tag;
  logic [LINES-1:0][WORDS-1:0][WORD_SIZE-1:0]  line_data;
  logic [WORDS-1:0][WORD_SIZE-1:0]             fill_line;

  assign cpu_a     = addr_t'(cpu_addr);
  assign fill_line = mem_rdata;
  assign hit       = line_valid[cpu_a.idx] && (line_tag[cpu_a.idx] == cpu_a.tag);
  assign cpu_rdata = line_data[cpu_a.idx][cpu_a.off];
  assign rd_done   = cpu_read && !cpu_write;

  // Fill target comes from the registered line address, not the live bus.
  genvar i;
  generate
    for (i = 0; i < LINES; i++) begin : g_line
      cache_line #(
        .WORD_SIZE  (WORD_SIZE),
        .OFFSET_BITS(OFFSET_BITS),
        .TAG_BITS   (TAG_BITS)
      ) u_line (
        .clk      (clk),
        .reset_n  (reset_n),
        .fill_en  (fill_en && (mem_addr[OFFSET_BITS +: INDEX_BITS] == INDEX_BITS'(i))),
        .fill_tag (mem_addr[WORD_SIZE-1 -: TAG_BITS]),
        .fill_data(fill_line),
        .wr_en    (wr_en && (cpu_a.idx == INDEX_BITS'(i))),
        .wr_off   (cpu_a.off),
        .wr_data  (cpu_wdata),
        .valid    (line_valid[i]),
        .tag      (line_tag[i]),
        .data     (line_data[i])
      );
    end
  endgenerate

  always_comb begin
    state_d     = state;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    cpu_ready   = 1'b0;
    fill_en     = 1'b0;
    wr_en       = 1'b0;
    miss_set    = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_write) begin
          state_d     = WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
        end else if (cpu_read) begin
          if (hit) begin
            cpu_ready = 1'b1;
          end else begin
            state_d    = FILL;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = {cpu_a.tag, cpu_a.idx, OFFSET_BITS'(0)};
            miss_set   = 1'b1;
          end
        end
      end
      FILL: begin
        if (mem_req && mem_ready) begin
          fill_en   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      WRITE: begin
        if (mem_req && mem_ready) begin
          cpu_ready = cpu_write || cpu_read;
          wr_en     = hit;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      miss_flag    <= 1'b0;
      access_count <= '0;
      hit_count    <= '0;
    end else begin
      state     <= state_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if (miss_set) miss_flag <= 1'b1;
      // A read that needed a fill completes on a later hit; miss_flag keeps it out of hit_count.
      if (cpu_ready) begin
        access_count <= access_count + WORD_SIZE'(1);
        if (rd_done && !miss_flag) hit_count <= hit_count + WORD_SIZE'(1);
        if (rd_done) miss_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: fills, hits, write-through, no-allocate,
// conflict eviction and reset abort, with a latency-driven memory stub.

module tb_cache_ctrl;
  localparam int W  = 16;
  localparam int LW = W * 4;

  localparam logic [LW-1:0] L10 = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
  localparam logic [LW-1:0] L40 = {16'h4003, 16'h4002, 16'h4001, 16'h4000};
  localparam logic [LW-1:0] L50 = {16'h5003, 16'h5002, 16'h5001, 16'h5000};
  localparam logic [LW-1:0] L30 = {16'h3003, 16'h3002, 16'h3001, 16'h3000};

  logic          clk = 1'b0;
  logic          reset_n, cpu_read, cpu_write, cpu_ready;
  logic          mem_req, mem_we, mem_ready;
  logic [W-1:0]  cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata;
  logic [W-1:0]  access_count, hit_count;
  logic [LW-1:0] mem_rdata;
  int            n_chk = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cpu_read    (cpu_read),
    .cpu_write   (cpu_write),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ready   (cpu_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .access_count(access_count),
    .hit_count   (hit_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Entered at a negedge with mem_req already high; mem_ready rises on the lat-th cycle.
  task automatic mem_serve(input string tag, input int lat, input logic [LW-1:0] line,
                           input logic exp_rdy);
    for (int c = 1; c <= lat; c++) begin
      mem_ready = (c == lat);
      mem_rdata = line;
      #1;
      chk({tag, "_req"}, mem_req, 1);
      chk({tag, "_busy_rdy"}, cpu_ready, (c == lat) ? exp_rdy : 1'b0);
      cyc();
    end
    mem_ready = 1'b0;
  endtask

  task automatic read_miss(input string tag, input logic [W-1:0] a, input int lat,
                           input logic [LW-1:0] line, input logic [W-1:0] exp_maddr,
                           input logic [W-1:0] exp_data);
    cpu_write = 1'b0;
    cpu_read  = 1'b1;
    cpu_addr  = a;
    #1;
    chk({tag, "_miss_rdy"}, cpu_ready, 0);
    cyc();
    #1;
    chk({tag, "_maddr"}, mem_addr, exp_maddr);
    chk({tag, "_mwe"}, mem_we, 0);
    mem_serve(tag, lat, line, 1'b0);
    #1;
    chk({tag, "_fill_rdy"}, cpu_ready, 1);
    chk({tag, "_rdata"}, cpu_rdata, exp_data);
  endtask

  initial begin
    reset_n = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    cyc(); cyc(); #1;
    chk("rst_req",   mem_req, 0);
    chk("rst_we",    mem_we, 0);
    chk("rst_addr",  mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_acc",   access_count, 0);
    chk("rst_hit",   hit_count, 0);
    chk("rst_rdy",   cpu_ready, 0);
    cyc();
    reset_n = 1'b1;

    // stray mem_ready with no request outstanding
    mem_ready = 1'b1;
    #1 chk("stray_rdy", cpu_ready, 0);
    cyc();
    mem_ready = 1'b0;
    #1 chk("stray_req", mem_req, 0);
    chk("stray_acc", access_count, 0);

    read_miss("rd12", 16'h0012, 3, L10, 16'h0010, 16'h000C);
    cyc(); #1;
    chk("rd12_acc", access_count, 1);
    chk("rd12_hit", hit_count, 0);

    cpu_addr = 16'h0013;
    #1;
    chk("rd13_rdy", cpu_ready, 1);
    chk("rd13_data", cpu_rdata, 16'h000D);
    cyc(); #1;
    chk("rd13_acc", access_count, 2);
    chk("rd13_hit", hit_count, 1);

    // write hit, with read also asserted: write must win
    cpu_write = 1'b1; cpu_read = 1'b1; cpu_addr = 16'h0011; cpu_wdata = 16'hBEEF;
    #1 chk("wr11_prio_rdy", cpu_ready, 0);
    cyc(); #1;
    chk("wr11_mwe", mem_we, 1);
    chk("wr11_maddr", mem_addr, 16'h0011);
    chk("wr11_mwdata", mem_wdata, 16'hBEEF);
    mem_serve("wr11", 2, '0, 1'b1);
    #1;
    chk("wr11_acc", access_count, 3);
    chk("wr11_hit", hit_count, 1);
    chk("wr11_req_lo", mem_req, 0);
    cpu_write = 1'b0;
    #1;
    chk("rd11_rdy", cpu_ready, 1);
    chk("rd11_data", cpu_rdata, 16'hBEEF);
    cyc(); #1;
    chk("rd11_acc", access_count, 4);
    chk("rd11_hit", hit_count, 2);

    // write miss: no allocate, so the following read must fill
    cpu_read = 1'b0; cpu_write = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'h1234;
    cyc(); #1;
    chk("wr40_mwe", mem_we, 1);
    chk("wr40_maddr", mem_addr, 16'h0040);
    mem_serve("wr40", 1, '0, 1'b1);
    read_miss("rd40", 16'h0040, 2, L40, 16'h0040, 16'h4000);
    cyc(); #1;
    chk("rd40_acc", access_count, 6);
    chk("rd40_hit", hit_count, 2);

    // conflict eviction on index 0
    read_miss("c10a", 16'h0010, 1, L10, 16'h0010, 16'h000A);
    cyc();
    read_miss("c50", 16'h0050, 1, L50, 16'h0050, 16'h5000);
    cyc();
    read_miss("c10b", 16'h0010, 1, L10, 16'h0010, 16'h000A);
    cyc(); #1;
    chk("conf_acc", access_count, 9);
    chk("conf_hit", hit_count, 2);

    // reset in the middle of a fill, with mem_ready arriving on the reset edge
    cpu_read = 1'b1; cpu_addr = 16'h0030;
    #1 chk("rf_miss_rdy", cpu_ready, 0);
    cyc(); #1;
    chk("rf_req", mem_req, 1);
    chk("rf_maddr", mem_addr, 16'h0030);
    reset_n = 1'b0; mem_ready = 1'b1; mem_rdata = L30;
    cyc();
    reset_n = 1'b1; mem_ready = 1'b0; cpu_read = 1'b0;
    #1;
    chk("rf_req_lo", mem_req, 0);
    chk("rf_acc", access_count, 0);
    chk("rf_hit", hit_count, 0);
    cyc();
    read_miss("rst12", 16'h0012, 3, L10, 16'h0010, 16'h000C);
    cyc(); #1;
    chk("rst12_acc", access_count, 1);
    chk("rst12_hit", hit_count, 0);
    cpu_read = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
